// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: operation modes and FSM states.
package shift_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_SLL  = 2'b00;
    localparam op_t OP_SRL  = 2'b01;
    localparam op_t OP_SRA  = 2'b10;
    localparam op_t OP_ROTR = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Width of a per-cycle shift amount able to represent 0..step inclusive.
    function automatic int unsigned step_amt_bits(input int unsigned step);
        return $clog2(step) + 1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts data by k (0..STEP) according to op.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic [WIDTH-1:0]          data_i,
    input  op_t                       op_i,
    input  logic [$clog2(STEP):0]     k_i,
    output logic [WIDTH-1:0]          data_o
);

    logic [2*WIDTH-1:0] rot_w;

    always_comb begin
        data_o = '0;
        // Rotating right is a right shift of the operand concatenated with itself.
        rot_w  = {data_i, data_i} >> k_i;
        case (op_i)
            OP_SLL:  data_o = data_i << k_i;
            OP_SRL:  data_o = data_i >> k_i;
            OP_SRA:  data_o = $signed(data_i) >>> k_i;
            OP_ROTR: data_o = rot_w[WIDTH-1:0];
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTR) moving at most STEP bits per clock,
// with a start/busy/done handshake; out_data_o is the working register itself.
module shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   out_data_o
);

    localparam int unsigned KW = step_amt_bits(STEP);

    logic [0:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    op_t                op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_data;

    // Per-cycle amount: the full STEP while enough remains, otherwise the remainder.
    always_comb begin
        if (32'(cnt_q) >= STEP) begin
            k = KW'(STEP);
        end else begin
            k = KW'(cnt_q);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .k_i    (k),
        .data_o (step_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    data_d  = in_data_i;
                    cnt_d   = shamt_i;
                    op_d    = op_i;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    data_d = step_data;
                    cnt_d  = cnt_q - SHAMT_W'(k);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            op_q    <= OP_SLL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign out_data_o = data_q;

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised multi-cycle shifter for the MIPS datapath. It generalises the fixed left-by-2 offset shifter to any data width, all four shift modes and a run-time shift amount. It shifts at most STEP bits per clock, trading latency for area, and uses a start/busy/done handshake. It serves SLL/SRL/SRA/SLLV/SRLV/SRAV and rotate in the execute stage, and the pipeline stalls while busy is high.

## Interface
- WIDTH, 32: data width; power of two, at least 4.
- STEP, 4: maximum bits shifted per cycle; power of two, 1..WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width; derived, not overridden.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- in_data  input  WIDTH  operand; captured on an accepted start.
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1; captured on an accepted start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid.
- out_data  output  WIDTH  result register; holds until the next accepted start.

## Operation
- States:
  - IDLE: busy=0. When start=1, capture in_data, shamt and op, then go to SHIFT.
  - SHIFT: busy=1. Each cycle with cnt>0, shift data_r by k=min(cnt,STEP) and set cnt-=k.
  - Leaving SHIFT: when cnt==0, go to IDLE with done<=1 and busy<=0.
- Each step shifts by k:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA replicates data_r[WIDTH-1].
  - ROTR moves the low bits into the top bits.
- Results must equal the one-shot reference: in<<s, in>>s, $signed(in)>>>s, or (in>>s)|(in<<(WIDTH-s)), with s=shamt.
- out_data is the data_r register itself. It is only guaranteed meaningful when done=1 and is stable after that until the next accepted start.
- start while busy=1: ignored, with no effect on the in-flight operation and no queuing.
- start in the cycle done=1: accepted, because busy is already 0. This gives back-to-back operation with no bubble.
- shamt=0: one pass through SHIFT with no shift; out_data=in_data.
- op and shamt changing after acceptance have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, out_data 0, cnt 0, op register 00.
- Reset asserted mid-operation aborts the operation. No done is produced, and after release the block is IDLE.
- Latency from the accepting edge to the edge that raises done is 1+ceil(shamt/STEP) cycles.
  - STEP=4, shamt=31: 9 cycles.
  - shamt=0: 1 cycle.
  - STEP=WIDTH: always 2 cycles, except 1 cycle for shamt=0.
- busy rises on the edge after acceptance and falls on the same edge that raises done.
- done is high for exactly one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package shift_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROTR.
  - state encoding: ST_IDLE, ST_SHIFT.
- Sub-module shift_step: a combinational single step.
  - Inputs: data, op, k (width $clog2(STEP)+1).
  - Output: data shifted by k per op, where k ≤ STEP.
  - The top-level FSM instantiates it once.

## Test plan
- SLL, in_data=0x00000001, shamt=2, STEP=4 -> out_data=0x00000004 (the legacy ×4 offset case), done 2 cycles after start, busy high for 2 cycles.
- SRA, in_data=0x80000000, shamt=31 -> out_data=0xFFFFFFFF with done at cycle 9. SRL with the same inputs -> 0x00000001.
- ROTR, in_data=0x12345678, shamt=8 -> 0x78123456, done at cycle 3. shamt=0 -> out_data=0x12345678, done at cycle 1.
- Start with SLL 0x1/shamt 4, hold start=1 with other operands while busy -> the second request is ignored. Then start SRL 0xF0/shamt 4 in the done cycle -> accepted immediately; result 0x0F, done 2 cycles later.
- Drop rst_n to 0 during SHIFT -> busy, done and out_data are 0 at once. After release, no stray done; a new op completes correctly.
- Randomised ops/shamt, WIDTH∈{8,32,64}, STEP∈{1,4,WIDTH} -> matches the one-shot model and the 1+ceil(shamt/STEP) latency.
